// File: rtl/trigger_sequencer_if.sv
// Bundles the trigger sequencer's control, configuration, detector and capture-buffer signals.
// The master side drives requests and probe data; the slave side is the sequencer.
interface trigger_sequencer_if #(
    parameter int DEPTH_W = 6
);
    logic               arm;
    logic               abort;
    logic               cfg_we;
    logic [1:0]         cfg_stage;
    logic [7:0]         cfg_pattern;
    logic [7:0]         cfg_mask;
    logic               cfg_edge;
    logic [1:0]         num_stages;
    logic [DEPTH_W-1:0] post_count;
    logic [7:0]         sample_in;
    logic               det;

    logic [7:0]         pattern;
    logic [7:0]         mask;
    logic               edge_only;
    logic               detect_only;
    logic               wr_en;
    logic [DEPTH_W-1:0] wr_addr;
    logic [7:0]         wr_data;
    logic [DEPTH_W-1:0] trig_addr;
    logic [1:0]         stage_idx;
    logic               busy;
    logic               triggered;
    logic               done;

    modport master (
        output arm, abort, cfg_we, cfg_stage, cfg_pattern, cfg_mask, cfg_edge,
               num_stages, post_count, sample_in, det,
        input  pattern, mask, edge_only, detect_only, wr_en, wr_addr, wr_data,
               trig_addr, stage_idx, busy, triggered, done
    );

    modport slave (
        input  arm, abort, cfg_we, cfg_stage, cfg_pattern, cfg_mask, cfg_edge,
               num_stages, post_count, sample_in, det,
        output pattern, mask, edge_only, detect_only, wr_en, wr_addr, wr_data,
               trig_addr, stage_idx, busy, triggered, done
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Multi-stage logic-analyser trigger sequencer: walks a stage table against an external
// pattern detector, streams samples into a circular capture buffer and stops post_count after trigger.
module trigger_sequencer #(
    parameter int DEPTH_W = 6,
    parameter int STAGES  = 4
) (
    input logic clk,
    input logic rst,
    trigger_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    localparam logic [2:0] STAGES_L = 3'(STAGES);

    state_t             state_q, state_d;
    logic [1:0]         stage_q, stage_d;
    logic [DEPTH_W-1:0] addr_q, addr_d;
    logic [DEPTH_W-1:0] trig_q, trig_d;
    logic [DEPTH_W-1:0] cnt_q, cnt_d;
    logic               trg_q, trg_d;
    logic               skip_q, skip_d;

    logic [7:0]         pat_q [STAGES];
    logic [7:0]         msk_q [STAGES];
    logic               edg_q [STAGES];

    logic               cfg_open;
    logic               tbl_we;
    logic               det_ok;

    assign cfg_open = (state_q == IDLE) || (state_q == DONE);
    assign tbl_we   = bus.cfg_we && cfg_open && ({1'b0, bus.cfg_stage} < STAGES_L);
    // The detector answers one cycle after its configuration changes, so that cycle's det is stale.
    assign det_ok   = bus.det && !skip_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        addr_d  = addr_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        trg_d   = trg_q;
        skip_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.arm) begin
                    state_d = ARMED;
                    stage_d = 2'd0;
                    addr_d  = '0;
                    trg_d   = 1'b0;
                    skip_d  = 1'b1;
                end
            end
            ARMED: begin
                addr_d = addr_q + 1'b1;
                if (det_ok) begin
                    if (stage_q < bus.num_stages) begin
                        stage_d = stage_q + 2'd1;
                        skip_d  = 1'b1;
                    end else if (stage_q == bus.num_stages) begin
                        trig_d  = addr_q;
                        trg_d   = 1'b1;
                        cnt_d   = bus.post_count;
                        state_d = (bus.post_count == '0) ? DONE : POST;
                    end
                end
            end
            POST: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q <= DEPTH_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort outranks everything, including a simultaneous arm.
        if (bus.abort) begin
            state_d = IDLE;
            stage_d = 2'd0;
            trg_d   = 1'b0;
            skip_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= 2'd0;
            addr_q  <= '0;
            trig_q  <= '0;
            cnt_q   <= '0;
            trg_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            addr_q  <= addr_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            trg_q   <= trg_d;
            skip_q  <= skip_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pat_q[i] <= 8'h00;
                msk_q[i] <= 8'h00;
                edg_q[i] <= 1'b0;
            end
        end else if (tbl_we) begin
            pat_q[bus.cfg_stage] <= bus.cfg_pattern;
            msk_q[bus.cfg_stage] <= bus.cfg_mask;
            edg_q[bus.cfg_stage] <= bus.cfg_edge;
        end
    end

    assign bus.pattern     = pat_q[stage_q];
    assign bus.mask        = msk_q[stage_q];
    assign bus.edge_only   = edg_q[stage_q];
    assign bus.detect_only = cfg_open;
    assign bus.busy        = (state_q == ARMED) || (state_q == POST);
    assign bus.wr_en       = (state_q == ARMED) || (state_q == POST);
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = bus.sample_in;
    assign bus.trig_addr   = trig_q;
    assign bus.stage_idx   = stage_q;
    assign bus.triggered   = trg_q;
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: expected buffer writes are queued as samples are driven
// and retired by a write monitor; status outputs are checked at scenario milestones.
module tb_trigger_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    trigger_sequencer_if #(.DEPTH_W(6)) bus ();

    trigger_sequencer #(.DEPTH_W(6), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One capture cycle: fresh probe sample, det level, and the write it should produce.
    task automatic cyc(input logic d, input logic wr, input logic [5:0] a);
        wr_t w;
        bus.sample_in = 8'($urandom);
        bus.det       = d;
        if (wr) begin
            w.a = a;
            w.d = bus.sample_in;
            exp_q.push_back(w);
        end
        tick();
        bus.det = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] s, input logic [7:0] p, input logic [7:0] m, input logic e);
        bus.cfg_we      = 1'b1;
        bus.cfg_stage   = s;
        bus.cfg_pattern = p;
        bus.cfg_mask    = m;
        bus.cfg_edge    = e;
        tick();
        bus.cfg_we      = 1'b0;
    endtask

    task automatic start(input logic [1:0] ns, input logic [5:0] pc);
        bus.num_stages = ns;
        bus.post_count = pc;
        bus.arm        = 1'b1;
        tick();
        bus.arm        = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.arm = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0; bus.cfg_stage = 2'd0;
        bus.cfg_pattern = 8'h00; bus.cfg_mask = 8'h00; bus.cfg_edge = 1'b0;
        bus.num_stages = 2'd0; bus.post_count = 6'd0; bus.sample_in = 8'h00; bus.det = 1'b0;

        tick(); tick();
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_wr_en",     32'(bus.wr_en),       32'd0);
        chk("rst_det_only",  32'(bus.detect_only), 32'd1);
        chk("rst_stage",     32'(bus.stage_idx),   32'd0);
        chk("rst_wr_addr",   32'(bus.wr_addr),     32'd0);
        chk("rst_trig_addr", 32'(bus.trig_addr),   32'd0);
        chk("rst_triggered", 32'(bus.triggered),   32'd0);
        chk("rst_done",      32'(bus.done),        32'd0);
        chk("rst_pattern",   32'(bus.pattern),     32'h00);
        rst = 1'b0;
        tick();

        cfg(2'd0, 8'hA5, 8'hFF, 1'b0);
        chk("cfg_pattern0", 32'(bus.pattern), 32'hA5);
        chk("cfg_mask0",    32'(bus.mask),    32'hFF);

        // Single stage, post_count=3, trigger on 5th armed cycle; stale det and re-arm ignored.
        start(2'd0, 6'd3);
        chk("t1_busy",     32'(bus.busy),        32'd1);
        chk("t1_det_only", 32'(bus.detect_only), 32'd0);
        chk("t1_wr_addr",  32'(bus.wr_addr),     32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.arm = (i == 2);
            cyc((i == 0) || (i == 4), 1'b1, 6'(i));
            if (i == 0) chk("t1_first_det_ignored", 32'(bus.triggered), 32'd0);
        end
        bus.arm = 1'b0;
        chk("t1_triggered", 32'(bus.triggered), 32'd1);
        chk("t1_trig_addr", 32'(bus.trig_addr), 32'd4);
        chk("t1_post_busy", 32'(bus.busy),      32'd1);
        for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 6'(5 + j));
        chk("t1_done",      32'(bus.done),        32'd1);
        chk("t1_wr_en",     32'(bus.wr_en),       32'd0);
        chk("t1_idle_busy", 32'(bus.busy),        32'd0);
        chk("t1_det_only1", 32'(bus.detect_only), 32'd1);
        cyc(1'b0, 1'b0, 6'd0);
        chk("t1_done_hold", 32'(bus.done),      32'd1);
        chk("t1_trig_hold", 32'(bus.trig_addr), 32'd4);
        chk("t1_sb_empty",  32'(exp_q.size()),  32'd0);

        // Two stages: det advances, held det right after the advance is ignored.
        cfg(2'd1, 8'h3C, 8'h0F, 1'b1);
        start(2'd1, 6'd1);
        chk("t2_stage0", 32'(bus.stage_idx), 32'd0);
        chk("t2_trg_clr", 32'(bus.triggered), 32'd0);
        chk("t2_done_clr", 32'(bus.done), 32'd0);
        chk("t2_addr_clr", 32'(bus.wr_addr), 32'd0);
        cyc(1'b0, 1'b1, 6'd0);
        cyc(1'b1, 1'b1, 6'd1);
        chk("t2_stage1",   32'(bus.stage_idx), 32'd1);
        chk("t2_pattern1", 32'(bus.pattern),   32'h3C);
        chk("t2_edge1",    32'(bus.edge_only), 32'd1);
        cyc(1'b1, 1'b1, 6'd2);
        chk("t2_held_ignored", 32'(bus.triggered), 32'd0);
        chk("t2_stage_hold",   32'(bus.stage_idx), 32'd1);
        cyc(1'b0, 1'b1, 6'd3);
        cyc(1'b1, 1'b1, 6'd4);
        chk("t2_triggered", 32'(bus.triggered), 32'd1);
        chk("t2_trig_addr", 32'(bus.trig_addr), 32'd4);
        cyc(1'b0, 1'b1, 6'd5);
        chk("t2_done",     32'(bus.done),     32'd1);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Address wrap with post_count=0: single write at trig_addr, done next cycle.
        start(2'd0, 6'd0);
        for (int i = 0; i <= 70; i++) cyc(i == 70, 1'b1, 6'(i));
        chk("t3_done",      32'(bus.done),      32'd1);
        chk("t3_trig_addr", 32'(bus.trig_addr), 32'd6);
        chk("t3_triggered", 32'(bus.triggered), 32'd1);
        chk("t3_wr_en",     32'(bus.wr_en),     32'd0);
        chk("t3_sb_empty",  32'(exp_q.size()),  32'd0);

        // Config write during POST ignored; arm+abort during POST resolves to abort.
        start(2'd0, 6'd10);
        cyc(1'b0, 1'b1, 6'd0);
        cyc(1'b1, 1'b1, 6'd1);
        bus.cfg_we = 1'b1; bus.cfg_stage = 2'd0;
        bus.cfg_pattern = 8'h11; bus.cfg_mask = 8'h22; bus.cfg_edge = 1'b1;
        cyc(1'b0, 1'b1, 6'd2);
        bus.cfg_we = 1'b0;
        chk("t4_pat_locked",  32'(bus.pattern),   32'hA5);
        chk("t4_mask_locked", 32'(bus.mask),      32'hFF);
        chk("t4_edge_locked", 32'(bus.edge_only), 32'd0);
        bus.arm = 1'b1; bus.abort = 1'b1;
        cyc(1'b0, 1'b1, 6'd3);
        bus.arm = 1'b0; bus.abort = 1'b0;
        chk("t4_busy",      32'(bus.busy),        32'd0);
        chk("t4_wr_en",     32'(bus.wr_en),       32'd0);
        chk("t4_done",      32'(bus.done),        32'd0);
        chk("t4_triggered", 32'(bus.triggered),   32'd0);
        chk("t4_stage",     32'(bus.stage_idx),   32'd0);
        chk("t4_det_only",  32'(bus.detect_only), 32'd1);
        cyc(1'b0, 1'b0, 6'd0);
        chk("t4_pat_kept",  32'(bus.pattern),     32'hA5);
        chk("t4_sb_empty",  32'(exp_q.size()),    32'd0);

        // Asynchronous reset mid-POST, then a fresh capture from power-up state.
        start(2'd0, 6'd5);
        cyc(1'b0, 1'b1, 6'd0);
        cyc(1'b1, 1'b1, 6'd1);
        cyc(1'b0, 1'b1, 6'd2);
        rst = 1'b1;
        #1;
        chk("t5_wr_en",      32'(bus.wr_en),       32'd0);
        chk("t5_busy",       32'(bus.busy),        32'd0);
        chk("t5_det_only",   32'(bus.detect_only), 32'd1);
        chk("t5_wr_addr",    32'(bus.wr_addr),     32'd0);
        chk("t5_trig_addr",  32'(bus.trig_addr),   32'd0);
        chk("t5_triggered",  32'(bus.triggered),   32'd0);
        chk("t5_done",       32'(bus.done),        32'd0);
        chk("t5_stage",      32'(bus.stage_idx),   32'd0);
        chk("t5_pattern",    32'(bus.pattern),     32'h00);
        chk("t5_mask",       32'(bus.mask),        32'h00);
        tick();
        rst = 1'b0;
        cyc(1'b0, 1'b0, 6'd0);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        start(2'd0, 6'd0);
        cyc(1'b1, 1'b1, 6'd0);
        cyc(1'b1, 1'b1, 6'd1);
        chk("t6_done",      32'(bus.done),      32'd1);
        chk("t6_trig_addr", 32'(bus.trig_addr), 32'd1);
        chk("t6_pattern",   32'(bus.pattern),   32'h00);
        chk("t6_sb_empty",  32'(exp_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 Parameter DEPTH_W, default 6, SHALL be capture-buffer address width (buffer holds 2^DEPTH_W samples).
REQ-002 Parameter STAGES, default 4, SHALL be number of trigger stages held in the config table; stage index width is 2.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 arm  in  1  SHALL be the start-capture request, sampled per cycle.
REQ-006 abort  in  1  SHALL be the cancel request, sampled per cycle.
REQ-007 cfg_we  in  1 / cfg_stage  in  2 / cfg_pattern  in  8 / cfg_mask  in  8 / cfg_edge  in  1  SHALL form the stage-table write port.
REQ-008 num_stages  in  2  SHALL select the last active stage; stages 0..num_stages are used.
REQ-009 post_count  in  DEPTH_W  SHALL be the number of samples written after the trigger sample.
REQ-010 sample_in  in  8  SHALL be the raw probe data.
REQ-011 det  in  1  SHALL be the detected flag from the pattern detector.
REQ-012 pattern  out  8 / mask  out  8 / edge_only  out  1 / detect_only  out  1  SHALL drive the pattern detector configuration.
REQ-013 wr_en  out  1 / wr_addr  out  DEPTH_W / wr_data  out  8  SHALL be the capture-buffer write port.
REQ-014 trig_addr  out  DEPTH_W / stage_idx  out  2 / busy  out  1 / triggered  out  1 / done  out  1  SHALL report status.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, POST and DONE.
REQ-016 cfg_we SHALL write {pattern, mask, edge} into table entry cfg_stage only in IDLE or DONE; writes in ARMED or POST SHALL be ignored.
REQ-017 pattern, mask and edge_only SHALL combinationally present the table entry at stage_idx.
REQ-018 detect_only SHALL be 1 in IDLE and DONE, and 0 in ARMED and POST.
REQ-019 IDLE or DONE with arm=1 SHALL enter ARMED next cycle and clear stage_idx, wr_addr, triggered and done.
REQ-020 ARMED and POST SHALL assert wr_en every cycle, with wr_data=sample_in; wr_addr SHALL increment after each write, modulo 2^DEPTH_W (wraps 2^DEPTH_W-1 -> 0).
REQ-021 ARMED with det=1 and stage_idx<num_stages SHALL increment stage_idx next cycle.
REQ-022 det SHALL be ignored on the first cycle after entering ARMED and on the first cycle after any stage_idx change (detector one-cycle latency).
REQ-023 ARMED with valid det=1 and stage_idx==num_stages SHALL latch trig_addr=current wr_addr, set triggered=1, load the post counter with post_count and enter POST.
REQ-024 post_count=0 SHALL go from the trigger cycle straight to DONE with no POST cycles.
REQ-025 POST SHALL write exactly post_count samples, decrementing the counter per write, and enter DONE after the write at which the counter reaches 0.
REQ-026 DONE SHALL hold done=1, wr_en=0, and keep trig_addr and triggered until the next arm or reset.
REQ-027 busy SHALL equal (state==ARMED or state==POST).
REQ-028 abort=1 in any state SHALL enter IDLE next cycle: clear stage_idx, triggered and done; wr_en=0 from that cycle.
REQ-029 Simultaneous arm and abort SHALL resolve to abort.
REQ-030 arm while busy SHALL be ignored.
REQ-031 num_stages changes while busy SHALL take effect immediately in the stage-advance and trigger comparisons.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, with stage_idx=0, wr_addr=0, trig_addr=0, post counter=0, triggered=0, done=0, wr_en=0, busy=0 and detect_only=1.
REQ-033 rst SHALL clear the whole stage table to pattern=0x00, mask=0x00, edge=0.
REQ-034 rst asserted mid-capture SHALL abandon the capture with no further writes; the first arm after rst deassertion SHALL behave as from power-up.

Verification
REQ-035 Single stage (num_stages=0, post_count=3): arm; det=1 on the 5th ARMED cycle (wr_addr=4) -> trig_addr=4, 3 POST writes at addresses 5,6,7, then done=1 with wr_en=0.
REQ-036 Two-stage sequence: det pulse in stage 0 -> stage_idx=1 next cycle; det held high on the following cycle is ignored; later det -> triggered=1.
REQ-037 Wrap: DEPTH_W=6, 70 ARMED cycles before trigger -> wr_addr wraps 63->0 and trig_addr=6.
REQ-038 post_count=0 -> DONE the cycle after trigger; exactly one write occurs at trig_addr.
REQ-039 abort and arm together during POST -> IDLE, done=0, triggered=0; a cfg_we issued during POST leaves the table unchanged.
REQ-040 rst pulse during POST -> all outputs at reset values asynchronously; the stage table reads 0.
